// File: rtl/ctl_pkg.sv
// ctl_pkg: opcode constants, state encoding and control-field encodings for multicycle_control
package ctl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7
  } state_e;
  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILL
  } cls_e;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RF  = 2'b10;
  localparam logic [1:0] ALU_IF  = 2'b11;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] PCS_RESULT = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b100;
endpackage

// File: rtl/mctl_decode.sv
// mctl_decode: combinational opcode/funct3 classifier with legality flag
module mctl_decode
  import ctl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output cls_e       cls,
  output logic       legal
);
  always_comb begin
    cls = opcode == OP_R      ? CLS_R      :
          opcode == OP_IALU   ? CLS_I      :
          opcode == OP_LOAD   ? CLS_LOAD   :
          opcode == OP_STORE  ? CLS_STORE  :
          opcode == OP_BRANCH ? CLS_BRANCH :
          opcode == OP_JAL    ? CLS_JAL    : CLS_ILL;
    // only BEQ/BNE are supported branches
    legal = cls != CLS_ILL && !(cls == CLS_BRANCH && funct3[2:1] != 2'b00);
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: one-state-per-cycle RV32I-subset sequencer with memory timeout trap.
// Define MCTL_PERF_EN to add cycle_count/instret_count performance counters.
module multicycle_control
  import ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [2:0] imm_type,
  output logic [2:0] state,
  output logic       trap,
  output logic       bus_error
`ifdef MCTL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bus_error_q, bus_error_d;
  logic waiting, expired, taken, legal;
  cls_e cls;
  mctl_decode u_dec (.opcode(opcode), .funct3(funct3), .cls(cls), .legal(legal));
  always_comb begin
    waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    // mem_ready has priority: expiry only fires on a cycle still waiting
    expired = MEM_TIMEOUT != 0 && waiting && cnt_q == CW'(MEM_TIMEOUT - 1);
    taken = zero ^ funct3[0];
    state_d = state_q;
    bus_error_d = bus_error_q;
    pc_write = 1'b0;
    ir_write = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    mem_to_reg = WB_ALU;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    alu_op = ALU_ADD;
    pc_src = PCS_RESULT;
    imm_type = IMM_I;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_4;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
        bus_error_d = bus_error_q | expired;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_type = cls == CLS_JAL ? IMM_J : IMM_B;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (cls)
          CLS_R: begin
            alu_src_a = SRCA_RS1;
            alu_op = ALU_RF;
            state_d = S_WB;
          end
          CLS_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op = ALU_IF;
            state_d = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_type = cls == CLS_STORE ? IMM_S : IMM_I;
            state_d = S_MEM;
          end
          CLS_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op = ALU_SUB;
            pc_write = taken;
            pc_src = taken ? PCS_ALUOUT : PCS_RESULT;
            state_d = S_FETCH;
          end
          CLS_JAL: begin
            reg_write = 1'b1;
            mem_to_reg = WB_PC;
            pc_write = 1'b1;
            pc_src = PCS_ALUOUT;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        mem_read = cls == CLS_LOAD;
        mem_write = cls == CLS_STORE;
        state_d = mem_ready ? (cls == CLS_LOAD ? S_WB : S_FETCH) : expired ? S_TRAP : S_MEM;
        bus_error_d = bus_error_q | expired;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_to_reg = cls == CLS_LOAD ? WB_MDR : WB_ALU;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : (waiting && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  assign state = state_q;
  assign trap = state_q == S_TRAP;
  assign bus_error = bus_error_q;
`ifdef MCTL_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d, instret_count_q, instret_count_d;
  always_comb begin
    cycle_count_d = cycle_count_q + 32'((state_q != S_IDLE && state_q != S_TRAP) ? 1 : 0);
    instret_count_d = instret_count_q + 32'((state_d == S_FETCH &&
      (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) ? 1 : 0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cycle_count_q <= '0;
      instret_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  assign cycle_count = cycle_count_q;
  assign instret_count = instret_count_q;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven cycle checks of multicycle_control with a scoreboard queue
module tb_multicycle_control;
  typedef struct packed {
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src;
    logic [2:0] imm_type, state;
    logic       trap, bus_error;
  } out_t;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, r;
    out_t       ex;
  } vec_t;
  localparam logic [6:0] R = 7'b0110011, IA = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, trap, bus_error;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src;
  logic [2:0] imm_type, state;
`ifdef MCTL_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif
  int tests = 0, fails = 0;
  out_t sb[$];
  vec_t tbl[34];
  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .imm_type(imm_type), .state(state),
    .trap(trap), .bus_error(bus_error)
`ifdef MCTL_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic out_t e(input logic [2:0] st, input logic [5:0] s, input logic [1:0] m2r,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                             input logic [1:0] pcs, input logic [2:0] imm, input logic tr,
                             input logic be);
    return {s, m2r, a, b, op, pcs, imm, st, tr, be};
  endfunction
  task automatic check(input string nm);
    out_t got, ex;
    got = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, imm_type, state, trap, bus_error};
    ex = sb.pop_front();
    tests++;
    if (got !== ex) begin
      fails++;
      $display("FAIL %s: got=%h exp=%h", nm, got, ex);
    end
  endtask
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic r,
                     input out_t ex, input string nm);
    opcode = op;
    funct3 = f3;
    zero = z;
    mem_ready = r;
    sb.push_back(ex);
    #1 check(nm);
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset(input string nm);
    rst = 1'b1;
    sb.push_back('0);
    #1 check(nm);
`ifdef MCTL_PERF_EN
    tests++;
    if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      fails++;
      $display("FAIL %s_perf: cycle=%0d instret=%0d exp 0", nm, cycle_count, instret_count);
    end
`endif
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  initial begin
    out_t idle, fetch, fwait, dec_b;
    idle  = e(0, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    fetch = e(1, 6'b110100, 0, 0, 1, 0, 0, 3'b000, 0, 0);
    fwait = e(1, 6'b000100, 0, 0, 1, 0, 0, 3'b000, 0, 0);
    dec_b = e(2, 6'b000000, 0, 2, 2, 0, 0, 3'b010, 0, 0);
    tbl[0]  = '{R, 0, 0, 1, idle};
    tbl[1]  = '{R, 0, 0, 1, fetch};
    tbl[2]  = '{R, 0, 0, 1, dec_b};
    tbl[3]  = '{R, 0, 0, 1, e(3, 6'b000000, 0, 1, 0, 2, 0, 3'b000, 0, 0)};
    tbl[4]  = '{R, 0, 0, 1, e(5, 6'b000001, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[5]  = '{LD, 2, 0, 1, fetch};
    tbl[6]  = '{LD, 2, 0, 1, dec_b};
    tbl[7]  = '{LD, 2, 0, 1, e(3, 6'b000000, 0, 1, 2, 0, 0, 3'b000, 0, 0)};
    tbl[8]  = '{LD, 2, 0, 0, e(4, 6'b001100, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[9]  = '{LD, 2, 0, 0, e(4, 6'b001100, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[10] = '{LD, 2, 0, 0, e(4, 6'b001100, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[11] = '{LD, 2, 0, 1, e(4, 6'b001100, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[12] = '{LD, 2, 0, 1, e(5, 6'b000001, 1, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[13] = '{BR, 1, 0, 1, fetch};
    tbl[14] = '{BR, 1, 0, 1, dec_b};
    tbl[15] = '{BR, 1, 0, 1, e(3, 6'b100000, 0, 1, 0, 1, 1, 3'b000, 0, 0)};
    tbl[16] = '{BR, 1, 1, 1, fetch};
    tbl[17] = '{BR, 1, 1, 1, dec_b};
    tbl[18] = '{BR, 1, 1, 1, e(3, 6'b000000, 0, 1, 0, 1, 0, 3'b000, 0, 0)};
    tbl[19] = '{JL, 0, 0, 1, fetch};
    tbl[20] = '{JL, 0, 0, 1, e(2, 6'b000000, 0, 2, 2, 0, 0, 3'b100, 0, 0)};
    tbl[21] = '{JL, 0, 0, 1, e(3, 6'b100001, 2, 0, 0, 0, 1, 3'b000, 0, 0)};
    tbl[22] = '{ST, 2, 0, 1, fetch};
    tbl[23] = '{ST, 2, 0, 1, dec_b};
    tbl[24] = '{ST, 2, 0, 1, e(3, 6'b000000, 0, 1, 2, 0, 0, 3'b001, 0, 0)};
    tbl[25] = '{ST, 2, 0, 1, e(4, 6'b001010, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[26] = '{IA, 0, 0, 1, fetch};
    tbl[27] = '{IA, 0, 0, 1, dec_b};
    tbl[28] = '{IA, 0, 0, 1, e(3, 6'b000000, 0, 1, 2, 3, 0, 3'b000, 0, 0)};
    tbl[29] = '{IA, 0, 0, 1, e(5, 6'b000001, 0, 0, 0, 0, 0, 3'b000, 0, 0)};
    tbl[30] = '{BR, 4, 0, 1, fetch};
    tbl[31] = '{BR, 4, 0, 1, dec_b};
    tbl[32] = '{BR, 4, 0, 1, e(7, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 1, 0)};
    tbl[33] = '{BR, 4, 0, 1, e(7, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 1, 0)};
    @(posedge clk);
    #2;
    do_reset("reset");
    for (int i = 0; i < 34; i++)
      cyc(tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].r, tbl[i].ex, $sformatf("vec%0d", i));
    do_reset("reset_after_trap");
    cyc(7'h7F, 0, 0, 1, idle, "ill_idle");
    cyc(7'h7F, 0, 0, 1, fetch, "ill_fetch");
    cyc(7'h7F, 0, 0, 1, dec_b, "ill_decode");
    for (int i = 0; i < 12; i++)
      cyc(7'h7F, 0, 0, 1, e(7, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 1, 0), $sformatf("ill_trap%0d", i));
    do_reset("reset_ill");
    cyc(R, 0, 0, 0, idle, "to_idle");
    for (int i = 0; i < 4; i++) cyc(R, 0, 0, 0, fwait, $sformatf("to_wait%0d", i));
    cyc(R, 0, 0, 0, e(7, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 1, 1), "to_trap");
    cyc(R, 0, 0, 1, e(7, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 1, 1), "to_trap_hold");
    do_reset("reset_to");
    cyc(R, 0, 0, 0, idle, "race_idle");
    for (int i = 0; i < 3; i++) cyc(R, 0, 0, 0, fwait, $sformatf("race_wait%0d", i));
    cyc(R, 0, 0, 1, fetch, "race_ready");
    cyc(R, 0, 0, 1, dec_b, "race_decode");
    do_reset("reset_race");
    cyc(ST, 2, 0, 1, idle, "st_idle");
    cyc(ST, 2, 0, 1, fetch, "st_fetch");
    cyc(ST, 2, 0, 1, dec_b, "st_decode");
    cyc(ST, 2, 0, 1, e(3, 6'b000000, 0, 1, 2, 0, 0, 3'b001, 0, 0), "st_exec");
    cyc(ST, 2, 0, 0, e(4, 6'b001010, 0, 0, 0, 0, 0, 3'b000, 0, 0), "st_mem0");
    opcode = ST;
    funct3 = 3'd2;
    mem_ready = 1'b0;
    sb.push_back(e(4, 6'b001010, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    #1 check("st_mem1");
    do_reset("reset_mid_mem");
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_left: got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
